// File: rtl/survivor_bus_pkg.sv
// Shared types and default constants for the survivor tristate bus arbiter.
package survivor_bus_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        TURNAROUND = 2'd2
    } arb_state_t;

    localparam int ARB_DEFAULT_N          = 4;
    localparam int ARB_DEFAULT_TURNAROUND = 1;
    localparam int ARB_DEFAULT_MAX_TENURE = 8;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: finds the first requester after 'last',
// scanning in rotated order and mapping the hit back to an absolute index.
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         found,
    output logic [W-1:0] winner
);

    logic [W+1:0] start;
    logic [W+1:0] idx;

    // Walk the rotated positions from farthest to nearest so the nearest hit wins.
    always_comb begin
        start  = (W+2)'(last) + (W+2)'(1);
        found  = |req;
        winner = '0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = start + (W+2)'(i);
            if (idx >= (W+2)'(N)) begin
                idx = idx - (W+2)'(N);
            end
            if (req[idx[W-1:0]]) begin
                winner = idx[W-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner selection for the shared tristate bus. Produces a
// registered one-hot-or-zero drive_en with a dead-time between owners.
// Optional macro ARB_TENURE_LIMIT_EN adds forced revocation after MAX_TENURE
// grant cycles when another requester is waiting.
module bus_arbiter
    import survivor_bus_pkg::*;
#(
    parameter int N                 = ARB_DEFAULT_N,
    parameter int TURNAROUND_CYCLES = ARB_DEFAULT_TURNAROUND,
    parameter int MAX_TENURE        = ARB_DEFAULT_MAX_TENURE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         drive_en,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 bus_busy,
    output logic                 preempt
);

    localparam int              W       = $clog2(N);
    localparam int              TA_W    = $clog2(TURNAROUND_CYCLES + 1);
    localparam logic [TA_W-1:0] TA_LOAD = TA_W'(TURNAROUND_CYCLES - 1);
    localparam logic [N-1:0]    ONE     = {{(N-1){1'b0}}, 1'b1};

    if (N < 2 || N > 16 || TURNAROUND_CYCLES < 1 || MAX_TENURE < 1) begin : g_bad_params
        $error("bus_arbiter: parameter out of range");
    end

    arb_state_t      state;
    arb_state_t      next_state;
    logic [W-1:0]    last;
    logic [W-1:0]    last_next;
    logic [W-1:0]    winner;
    logic            found;
    logic [TA_W-1:0] ta_count;
    logic [TA_W-1:0] ta_next;
    logic [N-1:0]    drive_next;
    logic [W-1:0]    grant_next;
    logic            busy_next;
    logic            arb_edge;
    logic            owner_done;
    logic            revoke_edge;

    rr_priority_picker #(
        .N(N),
        .W(W)
    ) u_picker (
        .req   (req),
        .last  (last),
        .found (found),
        .winner(winner)
    );

    assign arb_edge   = (state == IDLE) || ((state == TURNAROUND) && (ta_count == '0));
    assign owner_done = (state == GRANT) && !req[grant_id];

`ifdef ARB_TENURE_LIMIT_EN
    localparam int               TEN_W   = $clog2(MAX_TENURE + 1);
    localparam logic [TEN_W-1:0] TEN_MAX = TEN_W'(MAX_TENURE);

    logic [TEN_W-1:0] tenure;
    logic [TEN_W-1:0] tenure_next;
    logic             preempt_next;

    assign revoke_edge = (state == GRANT) && req[grant_id] && (tenure == TEN_MAX)
                         && (|(req & ~drive_en));
`else
    assign revoke_edge = 1'b0;
    assign preempt     = 1'b0;
`endif

    // State and output registers; reset drops every driver enable immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            drive_en <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            last     <= W'(N - 1);
            ta_count <= '0;
`ifdef ARB_TENURE_LIMIT_EN
            tenure   <= '0;
            preempt  <= 1'b0;
`endif
        end else begin
            state    <= next_state;
            drive_en <= drive_next;
            grant_id <= grant_next;
            bus_busy <= busy_next;
            last     <= last_next;
            ta_count <= ta_next;
`ifdef ARB_TENURE_LIMIT_EN
            tenure   <= tenure_next;
            preempt  <= preempt_next;
`endif
        end
    end

    // Next-state decision: arbitrate when idle or when the dead-time expires.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:       next_state = found ? GRANT : IDLE;
            GRANT:      if (owner_done || revoke_edge) next_state = TURNAROUND;
            TURNAROUND: if (arb_edge) next_state = found ? GRANT : IDLE;
            default:    next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and counters.
    always_comb begin
        drive_next   = drive_en;
        grant_next   = grant_id;
        busy_next    = bus_busy;
        last_next    = last;
        ta_next      = ta_count;
`ifdef ARB_TENURE_LIMIT_EN
        tenure_next  = tenure;
        preempt_next = 1'b0;
`endif
        case (state)
            IDLE, TURNAROUND: begin
                if (arb_edge) begin
                    if (found) begin
                        drive_next  = ONE << winner;
                        grant_next  = winner;
                        busy_next   = 1'b1;
                        last_next   = winner;
`ifdef ARB_TENURE_LIMIT_EN
                        tenure_next = TEN_W'(1);
`endif
                    end else begin
                        drive_next = '0;
                        grant_next = '0;
                        busy_next  = 1'b0;
                    end
                end else begin
                    ta_next = ta_count - TA_W'(1);
                end
            end
            GRANT: begin
                if (owner_done || revoke_edge) begin
                    drive_next   = '0;
                    grant_next   = '0;
                    busy_next    = 1'b0;
                    ta_next      = TA_LOAD;
`ifdef ARB_TENURE_LIMIT_EN
                    preempt_next = revoke_edge;
`endif
                end else begin
`ifdef ARB_TENURE_LIMIT_EN
                    if (tenure != TEN_MAX) begin
                        tenure_next = tenure + TEN_W'(1);
                    end
`endif
                end
            end
            default: begin
                drive_next = '0;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter. Two instances: one with a
// single turnaround cycle, one with three. Tenure checks run only when
// ARB_TENURE_LIMIT_EN is defined.
module tb_bus_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic [3:0] drive_en;
    logic [1:0] grant_id;
    logic       bus_busy;
    logic       preempt;
    logic [3:0] req_ta;
    logic [3:0] drive_en_ta;
    logic [1:0] grant_id_ta;
    logic       bus_busy_ta;
    logic       preempt_ta;

    int check_count = 0;
    int fail_count  = 0;

    bus_arbiter #(
        .N(4),
        .TURNAROUND_CYCLES(1),
        .MAX_TENURE(4)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .drive_en(drive_en),
        .grant_id(grant_id),
        .bus_busy(bus_busy),
        .preempt (preempt)
    );

    bus_arbiter #(
        .N(4),
        .TURNAROUND_CYCLES(3),
        .MAX_TENURE(4)
    ) dut_ta (
        .clock   (clock),
        .reset   (reset),
        .req     (req_ta),
        .drive_en(drive_en_ta),
        .grant_id(grant_id_ta),
        .bus_busy(bus_busy_ta),
        .preempt (preempt_ta)
    );

    // Free-running clock, period 10.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drive both request vectors, then wait to the next falling edge to sample.
    task automatic applyStimulus(input logic [3:0] r_main, input logic [3:0] r_ta);
        req    = r_main;
        req_ta = r_ta;
        @(negedge clock);
    endtask

    task automatic main_step(input string name, input logic [3:0] r, input logic [3:0] d,
                             input logic [1:0] g, input logic p);
        applyStimulus(r, 4'b0000);
        checkOutput({name, " drive_en"}, 32'(drive_en), 32'(d));
        checkOutput({name, " grant_id"}, 32'(grant_id), 32'(g));
        checkOutput({name, " bus_busy"}, 32'(bus_busy), 32'(d != 4'b0000));
        checkOutput({name, " preempt"},  32'(preempt),  32'(p));
        checkOutput({name, " onehot"},   32'($onehot0(drive_en)), 32'd1);
    endtask

    task automatic ta_step(input string name, input logic [3:0] r, input logic [3:0] d,
                           input logic [1:0] g);
        applyStimulus(4'b0000, r);
        checkOutput({name, " drive_en"}, 32'(drive_en_ta), 32'(d));
        checkOutput({name, " grant_id"}, 32'(grant_id_ta), 32'(g));
        checkOutput({name, " bus_busy"}, 32'(bus_busy_ta), 32'(d != 4'b0000));
        checkOutput({name, " onehot"},   32'($onehot0(drive_en_ta)), 32'd1);
    endtask

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence with hand-computed expectations.
    initial begin
        reset  = 1'b1;
        req    = 4'b0000;
        req_ta = 4'b0000;
        repeat (3) @(negedge clock);

        req    = 4'b1111;
        req_ta = 4'b1111;
        @(negedge clock);
        checkOutput("reset drive_en",    32'(drive_en),    32'd0);
        checkOutput("reset bus_busy",    32'(bus_busy),    32'd0);
        checkOutput("reset grant_id",    32'(grant_id),    32'd0);
        checkOutput("reset preempt",     32'(preempt),     32'd0);
        checkOutput("reset drive_en_ta", 32'(drive_en_ta), 32'd0);
        reset = 1'b0;

        main_step("first grant", 4'b1111, 4'b0001, 2'd0, 1'b0);

        main_step("rr e2",  4'b1111, 4'b0001, 2'd0, 1'b0);
        main_step("rr e3",  4'b1110, 4'b0000, 2'd0, 1'b0);
        main_step("rr e4",  4'b1111, 4'b0010, 2'd1, 1'b0);
        main_step("rr e5",  4'b1111, 4'b0010, 2'd1, 1'b0);
        main_step("rr e6",  4'b1101, 4'b0000, 2'd0, 1'b0);
        main_step("rr e7",  4'b1111, 4'b0100, 2'd2, 1'b0);
        main_step("rr e8",  4'b1111, 4'b0100, 2'd2, 1'b0);
        main_step("rr e9",  4'b1011, 4'b0000, 2'd0, 1'b0);
        main_step("rr e10", 4'b1111, 4'b1000, 2'd3, 1'b0);
        main_step("rr e11", 4'b1111, 4'b1000, 2'd3, 1'b0);
        main_step("rr e12", 4'b0111, 4'b0000, 2'd0, 1'b0);
        main_step("rr e13", 4'b1111, 4'b0001, 2'd0, 1'b0);

        main_step("wrap release", 4'b0000, 4'b0000, 2'd0, 1'b0);
        main_step("wrap idle",    4'b0000, 4'b0000, 2'd0, 1'b0);
        main_step("wrap g3",      4'b1000, 4'b1000, 2'd3, 1'b0);
        main_step("wrap g3 hold", 4'b1000, 4'b1000, 2'd3, 1'b0);
        main_step("wrap rel3",    4'b0000, 4'b0000, 2'd0, 1'b0);
        main_step("wrap g0",      4'b0001, 4'b0001, 2'd0, 1'b0);
        main_step("wrap g0 hold", 4'b0001, 4'b0001, 2'd0, 1'b0);

        main_step("mid rel0",  4'b0000, 4'b0000, 2'd0, 1'b0);
        main_step("mid g2",    4'b0100, 4'b0100, 2'd2, 1'b0);
        main_step("mid g2 h",  4'b0100, 4'b0100, 2'd2, 1'b0);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid reset drive_en", 32'(drive_en), 32'd0);
        checkOutput("mid reset bus_busy", 32'(bus_busy), 32'd0);
        checkOutput("mid reset grant_id", 32'(grant_id), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        main_step("post reset prio", 4'b1001, 4'b0001, 2'd0, 1'b0);

        ta_step("ta g1",    4'b0010, 4'b0010, 2'd1);
        ta_step("ta g1 h",  4'b0110, 4'b0010, 2'd1);
        ta_step("ta gap1",  4'b0100, 4'b0000, 2'd0);
        ta_step("ta gap2",  4'b0100, 4'b0000, 2'd0);
        ta_step("ta gap3",  4'b0100, 4'b0000, 2'd0);
        ta_step("ta g2",    4'b0100, 4'b0100, 2'd2);
        ta_step("ta rel2",  4'b0000, 4'b0000, 2'd0);

`ifdef ARB_TENURE_LIMIT_EN
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        main_step("ten g0 c1",   4'b0011, 4'b0001, 2'd0, 1'b0);
        main_step("ten g0 c2",   4'b0011, 4'b0001, 2'd0, 1'b0);
        main_step("ten g0 c3",   4'b0011, 4'b0001, 2'd0, 1'b0);
        main_step("ten g0 c4",   4'b0011, 4'b0001, 2'd0, 1'b0);
        main_step("ten revoke",  4'b0011, 4'b0000, 2'd0, 1'b1);
        main_step("ten g1",      4'b0011, 4'b0010, 2'd1, 1'b0);
        main_step("ten rel1",    4'b0001, 4'b0000, 2'd0, 1'b0);
        main_step("ten solo g0", 4'b0001, 4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            main_step($sformatf("ten solo hold %0d", i), 4'b0001, 4'b0001, 2'd0, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule
